// File: rtl/mac_tx_framer.sv
// Byte-wide Ethernet MAC transmit framer: preamble/SFD, payload, optional pad, CRC-32 FCS, IFG.
// Optional feature: define MAC_TX_PAD_EN to pad short frames up to MIN_FRAME bytes before the FCS.
module mac_tx_framer #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int IFG_BYTES      = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] mac_txd,
  output logic       mac_tx_en,
  output logic       mac_tx_er,
  output logic       busy,
  output logic       tx_underrun
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);
`ifdef MAC_TX_PAD_EN
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
`endif

  // Out-of-range parameters stop elaboration rather than building a broken framer.
  if (PREAMBLE_BYTES < 1 || PREAMBLE_BYTES > 15 || IFG_BYTES < 1 || IFG_BYTES > 255 ||
      MIN_FRAME < 1 || MIN_FRAME > 65535) begin : g_bad_params
    $error("mac_tx_framer: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_FCS,
    ST_ABORT,
    ST_IFG
`ifdef MAC_TX_PAD_EN
    , ST_PAD
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic [31:0] crc_reg, crc_next;
  logic [7:0]  txd_reg, txd_next;
  logic        en_reg, en_next;
  logic        er_reg, er_next;
  logic        ready_reg, ready_next;
  logic        busy_reg, busy_next;
  logic        underrun_reg, underrun_next;

  logic [31:0] fcs_word;
  logic [7:0]  cnt_inc;
  logic [15:0] byte_cnt_inc;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs_word     = ~crc_reg;
  assign cnt_inc      = cnt_reg + 8'd1;
  assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 8'd0;
      byte_cnt_reg <= 16'd0;
      crc_reg      <= CRC_INIT;
      txd_reg      <= 8'h00;
      en_reg       <= 1'b0;
      er_reg       <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      crc_reg      <= crc_next;
      txd_reg      <= txd_next;
      en_reg       <= en_next;
      er_reg       <= er_next;
      ready_reg    <= ready_next;
      busy_reg     <= busy_next;
      underrun_reg <= underrun_next;
    end
  end

  // Each register holds what the wire carries in the cycle after the edge,
  // so next-state and next-output are decided together.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    crc_next      = crc_reg;
    txd_next      = 8'h00;
    en_next       = 1'b0;
    er_next       = 1'b0;
    ready_next    = 1'b0;
    underrun_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (tx_valid) begin
          state_next    = ST_PREAMBLE;
          cnt_next      = 8'd0;
          byte_cnt_next = 16'd0;
          crc_next      = CRC_INIT;
          txd_next      = 8'h55;
          en_next       = 1'b1;
        end
      end

      ST_PREAMBLE: begin
        en_next = 1'b1;
        if (cnt_reg == PRE_LAST) begin
          state_next = ST_SFD;
          txd_next   = 8'hD5;
          ready_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
          txd_next = 8'h55;
        end
      end

      // SFD and DATA share the handshake; SFD always enters with ready high.
      ST_SFD, ST_DATA: begin
        en_next = 1'b1;
        if (ready_reg) begin
          if (tx_valid) begin
            state_next    = ST_DATA;
            txd_next      = tx_data;
            crc_next      = crc_byte(crc_reg, tx_data);
            byte_cnt_next = byte_cnt_inc;
            ready_next    = ~tx_last;
          end else begin
            state_next    = ST_ABORT;
            er_next       = 1'b1;
            underrun_next = 1'b1;
          end
        end else begin
`ifdef MAC_TX_PAD_EN
          if (byte_cnt_reg < MIN_LEN) begin
            state_next    = ST_PAD;
            crc_next      = crc_byte(crc_reg, 8'h00);
            byte_cnt_next = byte_cnt_inc;
          end else
`endif
          begin
            state_next = ST_FCS;
            cnt_next   = 8'd0;
            txd_next   = fcs_word[7:0];
          end
        end
      end

`ifdef MAC_TX_PAD_EN
      ST_PAD: begin
        en_next = 1'b1;
        if (byte_cnt_reg >= MIN_LEN) begin
          state_next = ST_FCS;
          cnt_next   = 8'd0;
          txd_next   = fcs_word[7:0];
        end else begin
          crc_next      = crc_byte(crc_reg, 8'h00);
          byte_cnt_next = byte_cnt_inc;
        end
      end
`endif

      // FCS goes out least-significant byte first; cnt_reg is the byte on the wire now.
      ST_FCS: begin
        if (cnt_reg[1:0] == 2'd3) begin
          state_next = ST_IFG;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_inc;
          en_next  = 1'b1;
          txd_next = fcs_word[{cnt_inc[1:0], 3'b000} +: 8];
        end
      end

      ST_ABORT: begin
        state_next = ST_IFG;
        cnt_next   = 8'd0;
      end

      ST_IFG: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign busy_next   = (state_next != ST_IDLE);

  assign tx_ready    = ready_reg;
  assign mac_txd     = txd_reg;
  assign mac_tx_en   = en_reg;
  assign mac_tx_er   = er_reg;
  assign busy        = busy_reg;
  assign tx_underrun = underrun_reg;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: directed frame table plus random frames, checked against a
// table-driven CRC frame model and a negedge wire monitor.
module tb_mac_tx_framer;

  localparam int PRE  = 7;
  localparam int MINF = 60;
  localparam int IFG  = 12;
`ifdef MAC_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] mac_txd;
  logic       mac_tx_en;
  logic       mac_tx_er;
  logic       busy;
  logic       tx_underrun;

  always #5 clock = ~clock;

  mac_tx_framer #(
    .PREAMBLE_BYTES(PRE),
    .MIN_FRAME(MINF),
    .IFG_BYTES(IFG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .mac_txd(mac_txd),
    .mac_tx_en(mac_tx_en),
    .mac_tx_er(mac_tx_er),
    .busy(busy),
    .tx_underrun(tx_underrun)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  pl[$];
  logic [7:0]  exp_bytes[$];
  int          exp_lens[$];
  bit          exp_errs[$];
  logic [7:0]  mon_bytes[$];
  int          mon_lens[$];
  bit          mon_errs[$];
  logic [31:0] crc_tab[256];

  int underrun_cnt = 0;
  int gap_at_rise  = -1;
  int cyc          = 0;
  int end_cyc      = -1000;
  bit mon_prev_en  = 1'b0;
  int mon_cur_len  = 0;
  bit mon_cur_err  = 1'b0;

  typedef struct {
    int          len;
    int          drop_at;
    int          rst_at;
    bit          b2b;
    bit          ascii;
    int          exp_wire;
    logic [31:0] exp_fcs;
    bit          chk_fcs;
  } vec_t;

  vec_t vecs[8];

  // Wire monitor: every mac_tx_en-high byte belongs to the current frame.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (mac_tx_en) begin
        if (!mon_prev_en) gap_at_rise = cyc - end_cyc - 1;
        mon_cur_len++;
        mon_bytes.push_back(mac_txd);
        if (mac_tx_er) mon_cur_err = 1'b1;
      end else if (mon_prev_en) begin
        mon_lens.push_back(mon_cur_len);
        mon_errs.push_back(mon_cur_err);
        mon_cur_len = 0;
        mon_cur_err = 1'b0;
        end_cyc = cyc - 1;
      end
      if (tx_underrun) underrun_cnt++;
      mon_prev_en = mac_tx_en;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic reset_check(input string name);
    check(name, longint'({mac_txd, mac_tx_en, mac_tx_er, tx_ready, busy, tx_underrun}), 0);
  endtask

  task automatic fill_payload(input int n, input bit ascii);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(ascii ? 8'(8'h31 + i) : 8'($urandom));
  endtask

  // Expected wire image of one frame, from the framing rules and a byte-table CRC.
  task automatic build_exp(input int n, input int drop_at, input int rst_at);
    logic [31:0] crc;
    logic [7:0]  b;
    int          body;
    int          len0;
    len0 = exp_bytes.size();
    for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    if (rst_at >= 0) begin
      for (int i = 0; i < rst_at; i++) exp_bytes.push_back(pl[i]);
      exp_errs.push_back(1'b0);
    end else if (drop_at >= 0) begin
      for (int i = 0; i < drop_at; i++) exp_bytes.push_back(pl[i]);
      exp_bytes.push_back(8'h00);
      exp_errs.push_back(1'b1);
    end else begin
      body = (PAD_ON && n < MINF) ? MINF : n;
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < body; i++) begin
        b = (i < n) ? pl[i] : 8'h00;
        exp_bytes.push_back(b);
        crc = (crc >> 8) ^ crc_tab[crc[7:0] ^ b];
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_bytes.push_back(crc[8*k +: 8]);
      exp_errs.push_back(1'b0);
    end
    exp_lens.push_back(exp_bytes.size() - len0);
  endtask

  // Drives pl[] on the valid/ready stream; called on a negedge, returns on a negedge.
  task automatic send_frame(input string tag, input int n, input int drop_at, input int rst_at);
    int i;
    bit fin;
    bit acc;
    i = 0;
    fin = 1'b0;
    tx_valid = 1'b1;
    tx_data = pl[0];
    tx_last = (n == 1);
    for (int t = 0; t < 3000 && !fin; t++) begin
      if (tx_ready && i == drop_at) begin
        tx_valid = 1'b0;
        tx_last = 1'b0;
        fin = 1'b1;
      end else if (tx_ready && rst_at >= 0 && i == rst_at) begin
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_last = 1'b0;
        fin = 1'b1;
      end else begin
        acc = tx_ready;
        @(negedge clock);
        if (acc) begin
          i++;
          if (i == n) begin
            tx_valid = 1'b0;
            tx_last = 1'b0;
            fin = 1'b1;
            check({tag, "_ready_after_last"}, longint'(tx_ready), 0);
          end else begin
            tx_data = pl[i];
            tx_last = (i == n - 1);
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s_send_timeout: accepted %0d bytes expected %0d", tag, i, n);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_frames(input string tag, input int n);
    int t;
    t = 0;
    while (mon_lens.size() < n && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_frames_seen"}, longint'(mon_lens.size() >= n), 1);
  endtask

  task automatic compare_frames(input string tag, output int first_len, output logic [31:0] first_fcs);
    int         el, ml, bad, fidx;
    bit         ee, me;
    logic [7:0] mq[$];
    logic [7:0] eq[$];
    logic [7:0] fa, fe;
    first_len = -1;
    first_fcs = 32'h0;
    fa = 8'h00;
    fe = 8'h00;
    while (exp_lens.size() > 0) begin
      el = exp_lens.pop_front();
      ee = exp_errs.pop_front();
      eq.delete();
      for (int i = 0; i < el; i++) eq.push_back(exp_bytes.pop_front());
      if (mon_lens.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_frame: got no frame expected %0d bytes", tag, el);
      end else begin
        ml = mon_lens.pop_front();
        me = mon_errs.pop_front();
        mq.delete();
        for (int i = 0; i < ml; i++) mq.push_back(mon_bytes.pop_front());
        if (first_len < 0) begin
          first_len = ml;
          if (ml >= 4) first_fcs = {mq[ml-1], mq[ml-2], mq[ml-3], mq[ml-4]};
        end
        check({tag, "_len"}, ml, el);
        check({tag, "_tx_er"}, longint'(me), longint'(ee));
        bad = 0;
        fidx = -1;
        for (int i = 0; i < ml && i < el; i++) begin
          if (mq[i] != eq[i]) begin
            bad++;
            if (fidx < 0) begin
              fidx = i;
              fa = mq[i];
              fe = eq[i];
            end
          end
        end
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL %s_bytes: %0d wrong, first at %0d got %02h expected %02h", tag, bad, fidx, fa, fe);
        end
      end
    end
    check({tag, "_extra_frames"}, mon_lens.size(), 0);
  endtask

  task automatic idle_check(input string tag, input int ur0, input int ur_exp);
    repeat (IFG + 2) @(negedge clock);
    check({tag, "_busy_idle"}, longint'(busy), 0);
    check({tag, "_ready_idle"}, longint'(tx_ready), 0);
    check({tag, "_underrun_pulses"}, underrun_cnt - ur0, ur_exp);
  endtask

  task automatic run_row(input string tag, input vec_t v);
    int          ur0, first_len;
    logic [31:0] first_fcs;
    ur0 = underrun_cnt;
    fill_payload(v.len, v.ascii);
    build_exp(v.len, v.drop_at, v.rst_at);
    send_frame(tag, v.len, v.drop_at, v.rst_at);
    if (v.rst_at >= 0) begin
      @(negedge clock);
      reset_check({tag, "_reset_outputs"});
      reset = 1'b0;
    end
    if (v.b2b) begin
      fill_payload(v.len, 1'b0);
      build_exp(v.len, -1, -1);
      send_frame({tag, "_b"}, v.len, -1, -1);
    end
    wait_frames(tag, v.b2b ? 2 : 1);
    compare_frames(tag, first_len, first_fcs);
    if (v.exp_wire >= 0) check({tag, "_wire_bytes"}, first_len, v.exp_wire);
    if (v.chk_fcs) check({tag, "_fcs"}, longint'(first_fcs), longint'(v.exp_fcs));
    if (v.b2b) check({tag, "_gap"}, gap_at_rise, IFG + 1);
    idle_check(tag, ur0, (v.drop_at >= 0) ? 1 : 0);
    $display("%s len %0d drop %0d rst %0d b2b %0d wire %0d", tag, v.len, v.drop_at, v.rst_at, v.b2b, first_len);
  endtask

  initial begin
    vec_t v;
    logic [31:0] c;
    for (int b = 0; b < 256; b++) begin
      c = 32'(b);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[b] = c;
    end

    //          len  drop rst b2b  ascii wire                                   fcs            chk_fcs
    vecs[0] = '{9,   -1,  -1, 1'b0, 1'b1, PRE + 1 + (PAD_ON ? MINF : 9) + 4,  32'hCBF43926, !PAD_ON};
    vecs[1] = '{100, 40,  -1, 1'b0, 1'b0, PRE + 1 + 40 + 1,                    32'h0,        1'b0};
    vecs[2] = '{1,   -1,  -1, 1'b0, 1'b0, PRE + 1 + (PAD_ON ? MINF : 1) + 4,  32'h0,        1'b0};
    vecs[3] = '{60,  -1,  -1, 1'b0, 1'b0, PRE + 1 + 60 + 4,                    32'h0,        1'b0};
    vecs[4] = '{59,  -1,  -1, 1'b0, 1'b0, PRE + 1 + (PAD_ON ? MINF : 59) + 4, 32'h0,        1'b0};
    vecs[5] = '{30,  -1,  -1, 1'b1, 1'b0, PRE + 1 + (PAD_ON ? MINF : 30) + 4, 32'h0,        1'b0};
    vecs[6] = '{50,  -1,  20, 1'b0, 1'b0, PRE + 1 + 20,                        32'h0,        1'b0};
    vecs[7] = '{1,   0,   -1, 1'b0, 1'b0, PRE + 1 + 1,                         32'h0,        1'b0};

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset_check("reset_state");
    reset = 1'b0;
    @(negedge clock);
    reset_check("idle_after_reset");

    for (int r = 0; r < 8; r++) run_row($sformatf("row%0d", r), vecs[r]);

    for (int r = 0; r < 14; r++) begin
      v.len      = int'($urandom_range(80, 1));
      v.drop_at  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(v.len - 1, 0)) : -1;
      v.rst_at   = -1;
      v.b2b      = 1'b0;
      v.ascii    = 1'b0;
      v.exp_wire = -1;
      v.exp_fcs  = 32'h0;
      v.chk_fcs  = 1'b0;
      run_row($sformatf("rand%0d", r), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
